mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 44 ++++
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
`timescale 1ns/1ps
// mem_access_ctrl_if: requester, response and memory-side signals of the access controller.
// Latency: none, wiring only.
// Backpressure: carries req_valid/req_ready and rsp_valid/rsp_ready handshakes unchanged.
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    // requester -> controller command
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic                  req_sel_i;
    logic [DATA_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;

    // controller -> requester response
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic                  rsp_err_o;

    // controller <-> memory (RAM/ROM behind an external select mux)
    logic                  mem_we_o;
    logic                  mem_sel_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    // controller side
    modport slave (
        input  req_valid_i, req_we_i, req_sel_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o
    );

    // requester plus memory side
    modport master (
        output req_valid_i, req_we_i, req_sel_i, req_addr_i, req_wdata_i,
        output rsp_ready_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// mem_access_ctrl: single-outstanding command sequencer in front of a RAM/ROM pair.
// Latency: error 1 cycle, RAM write 2 cycles, read RD_LAT+1 cycles from accept edge to rsp_valid_o.
// Backpressure: response held in RESP until rsp_ready_i; req_ready_o only in IDLE, no bypass.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1     // legal range 1..7
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // READ occupies RD_LAT cycles; the counter runs 0..RD_LAT-1 and the
    // memory data is captured on the edge that ends the last of them.
    localparam logic [2:0] LP_CNT_LAST = 3'(RD_LAT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;

    // memory-side command registers; they keep their value in IDLE/RESP
    logic                  r_mem_sel;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    // response registers
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    // one-cycle strobes from the next-state logic
    logic                  w_load_cmd;
    logic                  w_rsp_wr;
    logic                  w_rsp_err;
    logic                  w_rsp_rd;

    // Next-state and strobe decode; request inputs only looked at in IDLE,
    // rsp_ready_i only in RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_cmd  = 1'b0;
        w_rsp_wr    = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_rd    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    if (bus.req_we_i && bus.req_sel_i) begin
                        // ROM write: reject without touching the memory port
                        w_state_nxt = RESP;
                        w_rsp_err   = 1'b1;
                    end else if (bus.req_we_i) begin
                        w_state_nxt = WRITE;
                        w_load_cmd  = 1'b1;
                    end else begin
                        w_state_nxt = READ;
                        w_load_cmd  = 1'b1;
                        w_cnt_nxt   = 3'd0;
                    end
                end
            end
            WRITE: begin
                w_state_nxt = RESP;
                w_rsp_wr    = 1'b1;
            end
            READ: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = RESP;
                    w_rsp_rd    = 1'b1;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 3'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // State and read-latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the accepted command; these drive the memory port directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_sel   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_load_cmd) begin
            r_mem_sel   <= bus.req_sel_i;
            r_mem_addr  <= bus.req_addr_i;
            r_mem_wdata <= bus.req_wdata_i;
        end
    end

    // Build the response; it is frozen for the whole RESP residency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_err  <= 1'b0;
            r_rsp_data <= '0;
        end else if (w_rsp_err) begin
            r_rsp_err  <= 1'b1;
            r_rsp_data <= '0;
        end else if (w_rsp_wr) begin
            r_rsp_err  <= 1'b0;
            r_rsp_data <= '0;
        end else if (w_rsp_rd) begin
            r_rsp_err  <= 1'b0;
            r_rsp_data <= bus.mem_rdata_i;
        end
    end

    // Ready is masked by rst so it reads 0 during reset although the FSM sits in IDLE.
    assign bus.req_ready_o = (r_state == IDLE) && !rst;
    assign bus.rsp_valid_o = (r_state == RESP);
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.rsp_data_o  = r_rsp_data;

    // Write enable decoded from state so async reset drops it immediately.
    assign bus.mem_we_o    = (r_state == WRITE);
    assign bus.mem_sel_o   = r_mem_sel;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;

    // A stalled response must not change underneath the requester.
    a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.rsp_valid_o && !bus.rsp_ready_i) |=> ($stable(bus.rsp_data_o) && $stable(bus.rsp_err_o)));

    // A write strobe never lasts more than one cycle.
    a_we_pulse: assert property (@(posedge clk) disable iff (rst)
        bus.mem_we_o |=> !bus.mem_we_o);

    // The memory address cannot move while a read is in flight.
    a_rd_addr_hold: assert property (@(posedge clk) disable iff (rst)
        (r_state == READ) |=> $stable(bus.mem_addr_o) && $stable(bus.mem_sel_o));

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// tb_mem_access_ctrl: vector table plus corner sequences, responses checked through a queue.
// Latency: checks accept-to-response cycle counts for error, write and read paths.
// Backpressure: holds rsp_ready_i low to check response stability and no early acceptance.
module tb_mem_access_ctrl;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_WIDTH(DW)) bus1 ();
    mem_access_ctrl_if #(.DATA_WIDTH(DW)) bus3 ();

    mem_access_ctrl #(.DATA_WIDTH(DW), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mem_access_ctrl #(.DATA_WIDTH(DW), .RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- memory models ----------------
    function automatic logic [31:0] rom_val(input logic [31:0] a);
        return 32'hC0DE_0000 | (a & 32'h0000_FFFF);
    endfunction

    // RD_LAT=1 memory: data for the current address within the same cycle
    logic [31:0] ram1 [0:255];
    assign bus1.mem_rdata_i = bus1.mem_sel_o ? rom_val(bus1.mem_addr_o) : ram1[bus1.mem_addr_o[7:0]];

    int          we_cnt1 = 0;
    logic [31:0] we_addr1;
    logic [31:0] we_data1;
    always @(posedge clk) begin
        if (bus1.mem_we_o) begin
            ram1[bus1.mem_addr_o[7:0]] <= bus1.mem_wdata_o;
            we_cnt1  <= we_cnt1 + 1;
            we_addr1 <= bus1.mem_addr_o;
            we_data1 <= bus1.mem_wdata_o;
        end
    end

    // RD_LAT=3 memory: data reflects the address presented two cycles earlier
    logic [32:0] hist3 [0:1];
    always @(posedge clk) begin
        hist3[0] <= {bus3.mem_sel_o, bus3.mem_addr_o};
        hist3[1] <= hist3[0];
    end
    assign bus3.mem_rdata_i = hist3[1][32] ? rom_val(hist3[1][31:0]) : 32'h0BAD_0000;

    // ---------------- scoreboard for dut1 ----------------
    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb_q[$];

    always @(negedge clk) begin
        if (!rst && bus1.rsp_valid_o && bus1.rsp_ready_i) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: response err=%0b data=0x%0h with nothing expected",
                         bus1.rsp_err_o, bus1.rsp_data_o);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                chk1("sb_err", bus1.rsp_err_o, e.err);
                chk32("sb_data", bus1.rsp_data_o, e.data);
            end
        end
    end

    // handshake bookkeeping for dut1
    int cyc     = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int hs_cnt  = 0;
    int hs_cyc  = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus1.req_valid_i && bus1.req_ready_o) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc;
        end
        if (bus1.rsp_valid_o && bus1.rsp_ready_i) begin
            hs_cnt <= hs_cnt + 1;
            hs_cyc <= cyc;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic        sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_we;
        int          hold;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    // Entered and left at posedge+1; dut1 expected idle.
    task automatic run_vec(input vec_t v);
        int  lat;
        int  we0;
        bit  ok;
        we0 = we_cnt1;
        bus1.req_we_i    = v.we;
        bus1.req_sel_i   = v.sel;
        bus1.req_addr_i  = v.addr;
        bus1.req_wdata_i = v.wdata;
        bus1.req_valid_i = 1'b1;
        bus1.rsp_ready_i = 1'b0;
        sb_q.push_back('{err: v.exp_err, data: v.exp_data});
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.req_ready_o) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus1.req_valid_i = 1'b0;
        if (!ok) begin
            timeout("vec_accept");
            return;
        end
        lat = 1;
        ok  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.rsp_valid_o) begin
                ok = 1;
                break;
            end
            if (!v.we) begin
                chk32("rd_addr_hold", bus1.mem_addr_o, v.addr);
                chk1("rd_sel_hold", bus1.mem_sel_o, v.sel);
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!ok) begin
            timeout("vec_rsp");
            return;
        end
        chk32("latency", lat, v.exp_lat);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk1("bp_valid", bus1.rsp_valid_o, 1'b1);
            chk32("bp_data", bus1.rsp_data_o, v.exp_data);
            chk1("bp_err", bus1.rsp_err_o, v.exp_err);
            chk1("bp_req_ready", bus1.req_ready_o, 1'b0);
        end
        @(posedge clk); #1;
        bus1.rsp_ready_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus1.rsp_ready_i = 1'b0;
        @(negedge clk);
        chk1("idle_ready", bus1.req_ready_o, 1'b1);
        chk1("idle_no_rsp", bus1.rsp_valid_o, 1'b0);
        chk32("we_pulses", we_cnt1 - we0, v.exp_we);
        if (v.exp_we != 0) begin
            chk32("we_addr", we_addr1, v.addr);
            chk32("we_data", we_data1, v.wdata);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  we0;
        int  acc0;
        int  hs0;
        int  lat;
        int  hold_cnt;
        bit  ok;

        vecs[0] = '{we:1'b1, sel:1'b0, addr:32'h10, wdata:32'hDEADBEEF, exp_err:1'b0, exp_data:32'h0,        exp_lat:2, exp_we:1, hold:0};
        vecs[1] = '{we:1'b0, sel:1'b0, addr:32'h10, wdata:32'h0,        exp_err:1'b0, exp_data:32'hDEADBEEF, exp_lat:2, exp_we:0, hold:5};
        vecs[2] = '{we:1'b1, sel:1'b1, addr:32'h4,  wdata:32'h11112222, exp_err:1'b1, exp_data:32'h0,        exp_lat:1, exp_we:0, hold:2};
        vecs[3] = '{we:1'b0, sel:1'b1, addr:32'h8,  wdata:32'h0,        exp_err:1'b0, exp_data:32'hC0DE0008, exp_lat:2, exp_we:0, hold:0};
        vecs[4] = '{we:1'b1, sel:1'b0, addr:32'h20, wdata:32'h12345678, exp_err:1'b0, exp_data:32'h0,        exp_lat:2, exp_we:1, hold:1};
        vecs[5] = '{we:1'b0, sel:1'b0, addr:32'h20, wdata:32'h0,        exp_err:1'b0, exp_data:32'h12345678, exp_lat:2, exp_we:0, hold:0};
        vecs[6] = '{we:1'b0, sel:1'b0, addr:32'h10, wdata:32'h0,        exp_err:1'b0, exp_data:32'hDEADBEEF, exp_lat:2, exp_we:0, hold:0};
        vecs[7] = '{we:1'b0, sel:1'b1, addr:32'h4,  wdata:32'h0,        exp_err:1'b0, exp_data:32'hC0DE0004, exp_lat:2, exp_we:0, hold:0};

        bus1.req_valid_i = 1'b0; bus1.req_we_i = 1'b0; bus1.req_sel_i = 1'b0;
        bus1.req_addr_i  = '0;   bus1.req_wdata_i = '0; bus1.rsp_ready_i = 1'b0;
        bus3.req_valid_i = 1'b0; bus3.req_we_i = 1'b0; bus3.req_sel_i = 1'b0;
        bus3.req_addr_i  = '0;   bus3.req_wdata_i = '0; bus3.rsp_ready_i = 1'b0;

        // ---- reset values ----
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_req_ready", bus1.req_ready_o, 1'b0);
        chk1("rst_rsp_valid", bus1.rsp_valid_o, 1'b0);
        chk1("rst_rsp_err", bus1.rsp_err_o, 1'b0);
        chk32("rst_rsp_data", bus1.rsp_data_o, 32'h0);
        chk1("rst_mem_we", bus1.mem_we_o, 1'b0);
        chk1("rst_mem_sel", bus1.mem_sel_o, 1'b0);
        chk32("rst_mem_addr", bus1.mem_addr_o, 32'h0);
        chk32("rst_mem_wdata", bus1.mem_wdata_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_ready", bus1.req_ready_o, 1'b1);
        @(posedge clk); #1;

        // ---- table-driven commands on RD_LAT=1 ----
        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // ---- reset in the middle of a RAM write ----
        we0 = we_cnt1;
        bus1.req_we_i = 1'b1; bus1.req_sel_i = 1'b0;
        bus1.req_addr_i = 32'h40; bus1.req_wdata_i = 32'h55AA55AA;
        bus1.req_valid_i = 1'b1;
        @(negedge clk);
        chk1("rstw_ready", bus1.req_ready_o, 1'b1);
        @(posedge clk); #1;
        bus1.req_valid_i = 1'b0;
        #2;
        chk1("rstw_we_high", bus1.mem_we_o, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rstw_we_dropped", bus1.mem_we_o, 1'b0);
        chk1("rstw_no_rsp", bus1.rsp_valid_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("rstw_ready_after", bus1.req_ready_o, 1'b1);
        chk1("rstw_no_rsp_after", bus1.rsp_valid_o, 1'b0);
        chk32("rstw_no_we_edge", we_cnt1 - we0, 0);
        @(posedge clk); #1;

        // ---- RD_LAT=3 ROM read sweep ----
        bus3.req_we_i = 1'b0; bus3.req_sel_i = 1'b1;
        bus3.req_addr_i = 32'h8; bus3.req_valid_i = 1'b1;
        @(negedge clk);
        chk1("lat3_ready", bus3.req_ready_o, 1'b1);
        @(posedge clk); #1;
        bus3.req_valid_i = 1'b0;
        lat = 1;
        hold_cnt = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus3.mem_addr_o == 32'h8 && bus3.mem_sel_o) hold_cnt++;
            if (bus3.rsp_valid_o) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!ok) timeout("lat3_rsp");
        chk32("lat3_latency", lat, 4);
        chk32("lat3_addr_held", hold_cnt, 4);
        chk32("lat3_data", bus3.rsp_data_o, 32'hC0DE0008);
        chk1("lat3_err", bus3.rsp_err_o, 1'b0);
        @(posedge clk); #1;
        bus3.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus3.rsp_ready_i = 1'b0;
        @(negedge clk);
        chk1("lat3_idle", bus3.req_ready_o, 1'b1);
        @(posedge clk); #1;

        // ---- back-to-back with req_valid_i held high ----
        we0  = we_cnt1;
        acc0 = acc_cnt;
        hs0  = hs_cnt;
        bus1.req_we_i = 1'b1; bus1.req_sel_i = 1'b0;
        bus1.req_addr_i = 32'h30; bus1.req_wdata_i = 32'hCAFEF00D;
        bus1.req_valid_i = 1'b1;
        bus1.rsp_ready_i = 1'b1;
        sb_q.push_back('{err: 1'b0, data: 32'h0});
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (acc_cnt == acc0 + 1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("b2b_first_accept");
        bus1.req_we_i = 1'b0;
        bus1.req_wdata_i = 32'h0;
        sb_q.push_back('{err: 1'b0, data: 32'hCAFEF00D});
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (acc_cnt == acc0 + 2) begin
                ok = 1;
                break;
            end
        end
        bus1.req_valid_i = 1'b0;
        if (!ok) timeout("b2b_second_accept");
        chk32("b2b_rsp_before_2nd", hs_cnt - hs0, 1);
        chk32("b2b_gap", acc_cyc - hs_cyc, 1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (hs_cnt == hs0 + 2) begin
                ok = 1;
                break;
            end
        end
        bus1.rsp_ready_i = 1'b0;
        if (!ok) timeout("b2b_second_rsp");
        chk32("b2b_we_pulses", we_cnt1 - we0, 1);
        @(negedge clk);
        chk1("b2b_idle", bus1.req_ready_o, 1'b1);

        chk32("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
